// File: rtl/detection_result_collector_if.sv
// detection_result_collector_if: dispatch, result, detection and status bundle for the collector
interface detection_result_collector_if #(
  parameter int NUM_CORES = 4,
  parameter int CORE_W = 2,
  parameter int X_W = 10,
  parameter int Y_W = 10,
  parameter int CNT_W = 20
);
  logic start;
  logic [CNT_W-1:0] total_windows;
  logic dispatch_valid;
  logic [CORE_W-1:0] dispatch_core;
  logic [X_W-1:0] dispatch_x;
  logic [Y_W-1:0] dispatch_y;
  logic [NUM_CORES-1:0] res_valid;
  logic [NUM_CORES-1:0] res_passfail;
  logic [NUM_CORES-1:0] res_taken;
  logic det_valid;
  logic det_ready;
  logic [X_W-1:0] det_x;
  logic [Y_W-1:0] det_y;
  logic [CNT_W-1:0] windows_done;
  logic [CNT_W-1:0] detections;
  logic frame_done;
  logic overflow;
  modport master (
    output start, total_windows, dispatch_valid, dispatch_core, dispatch_x, dispatch_y,
    output res_valid, res_passfail, det_ready,
    input res_taken, det_valid, det_x, det_y, windows_done, detections, frame_done, overflow
  );
  modport slave (
    input start, total_windows, dispatch_valid, dispatch_core, dispatch_x, dispatch_y,
    input res_valid, res_passfail, det_ready,
    output res_taken, det_valid, det_x, det_y, windows_done, detections, frame_done, overflow
  );
endinterface

// File: rtl/detection_result_collector.sv
// detection_result_collector: round-robin verdict collection, coordinate tagging, detection FIFO and frame counters
module detection_result_collector #(
  parameter int NUM_CORES = 4,
  parameter int CORE_W = 2,
  parameter int X_W = 10,
  parameter int Y_W = 10,
  parameter int CNT_W = 20,
  parameter int FIFO_DEPTH = 8
) (
  input logic clk,
  input logic reset,
  detection_result_collector_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int C_W = X_W + Y_W;
  logic [C_W-1:0] coord_q [NUM_CORES];
  logic [C_W-1:0] coord_d [NUM_CORES];
  logic [C_W-1:0] mem_q [FIFO_DEPTH];
  logic [C_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PTR_W:0] cnt_q, cnt_d;
  logic [CORE_W-1:0] rr_q, rr_d, gnt, idx;
  logic [CNT_W-1:0] win_q, win_d, det_q, det_d, total_q, total_d, win_base, det_base;
  logic frame_q, frame_d, ovf_q, ovf_d, active_q, active_d;
  logic empty, full, pop, push, found, can_push;
  logic [NUM_CORES-1:0] elig, taken;
  always_comb begin
    empty = cnt_q == '0;
    full = cnt_q == (PTR_W+1)'(FIFO_DEPTH);
    pop = ~empty & bus.det_ready;
    can_push = ~full | pop;
    elig = bus.res_valid & (~bus.res_passfail | {NUM_CORES{can_push}});
    found = 1'b0;
    gnt = '0;
    idx = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      idx = CORE_W'((int'(rr_q) + k) % NUM_CORES);
      if (!found && elig[idx]) begin
        found = 1'b1;
        gnt = idx;
      end
    end
    found = found & ~reset;
    taken = found ? NUM_CORES'(1) << gnt : '0;
    push = found & bus.res_passfail[gnt];
    rr_d = found ? ((int'(gnt) == NUM_CORES - 1) ? '0 : gnt + 1'b1) : rr_q;
    // a grant alongside start counts as the first result of the new frame
    win_base = bus.start ? '0 : win_q;
    det_base = bus.start ? '0 : det_q;
    win_d = (found && win_base != '1) ? win_base + 1'b1 : win_base;
    det_d = (push && det_base != '1) ? det_base + 1'b1 : det_base;
    total_d = bus.start ? bus.total_windows : total_q;
    active_d = active_q | bus.start;
    cnt_d = cnt_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    wr_d = push ? wr_q + 1'b1 : wr_q;
    rd_d = pop ? rd_q + 1'b1 : rd_q;
    mem_d = mem_q;
    if (push) mem_d[wr_q] = coord_q[gnt];
    coord_d = coord_q;
    if (bus.dispatch_valid) coord_d[bus.dispatch_core] = {bus.dispatch_x, bus.dispatch_y};
    ovf_d = ovf_q | (bus.dispatch_valid & bus.res_valid[bus.dispatch_core] & ~taken[bus.dispatch_core]);
    frame_d = active_d & ((frame_q & ~bus.start) | (win_d == total_d && cnt_d == '0));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      coord_q <= '{default: '0};
      mem_q <= '{default: '0};
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      rr_q <= '0;
      win_q <= '0;
      det_q <= '0;
      total_q <= '0;
      frame_q <= 1'b0;
      ovf_q <= 1'b0;
      active_q <= 1'b0;
    end else begin
      coord_q <= coord_d;
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      rr_q <= rr_d;
      win_q <= win_d;
      det_q <= det_d;
      total_q <= total_d;
      frame_q <= frame_d;
      ovf_q <= ovf_d;
      active_q <= active_d;
    end
  end
  assign bus.res_taken = taken;
  assign bus.det_valid = ~empty;
  assign bus.det_x = empty ? '0 : mem_q[rd_q][C_W-1:Y_W];
  assign bus.det_y = empty ? '0 : mem_q[rd_q][Y_W-1:0];
  assign bus.windows_done = win_q;
  assign bus.detections = det_q;
  assign bus.frame_done = frame_q;
  assign bus.overflow = ovf_q;
endmodule
